// File: rtl/axi3_regfile_s.sv
// AXI3 slave register file for a PS7 GP port: N_REG byte-strobed 32-bit registers,
// INCR/FIXED bursts, independent single-outstanding write and read paths, LED mirror.
module axi3_regfile_s #(
    parameter int unsigned N_REG   = 8,
    parameter int unsigned ID_W    = 12,
    parameter int unsigned LED_W   = 8,
    parameter int unsigned LED_REG = 0
) (
    input  logic              i_clk0,
    input  logic              i_rst,
    input  logic [ID_W-1:0]   i_awid,
    input  logic [31:0]       i_awaddr,
    input  logic [3:0]        i_awlen,
    input  logic [2:0]        i_awsize,
    input  logic [1:0]        i_awburst,
    input  logic              i_awvalid,
    output logic              o_awready,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_wstrb,
    input  logic              i_wlast,
    input  logic              i_wvalid,
    output logic              o_wready,
    output logic [ID_W-1:0]   o_bid,
    output logic [1:0]        o_bresp,
    output logic              o_bvalid,
    input  logic              i_bready,
    input  logic [ID_W-1:0]   i_arid,
    input  logic [31:0]       i_araddr,
    input  logic [3:0]        i_arlen,
    input  logic [2:0]        i_arsize,
    input  logic [1:0]        i_arburst,
    input  logic              i_arvalid,
    output logic              o_arready,
    output logic [ID_W-1:0]   o_rid,
    output logic [31:0]       o_rdata,
    output logic [1:0]        o_rresp,
    output logic              o_rlast,
    output logic              o_rvalid,
    input  logic              i_rready,
    output logic [LED_W-1:0]  o_led
);

    localparam int unsigned IDX_W = (N_REG > 1) ? $clog2(N_REG) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    function automatic logic in_range(input logic [9:0] idx);
        return 11'(idx) < 11'(N_REG);
    endfunction

    // SLVERR dominates DECERR, which dominates OKAY
    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
        if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
        return RESP_OKAY;
    endfunction

    logic [31:0] regs [N_REG];

    logic [1:0]  w_state, w_next;
    logic [9:0]  w_idx;
    logic [3:0]  w_len, w_cnt;
    logic        w_fixed, w_ill;
    logic        w_idle;

    logic [0:0]  r_state, r_next;
    logic [9:0]  r_idx;
    logic [3:0]  r_len, r_cnt;
    logic        r_fixed, r_ill;
    logic        r_idle;

    logic        aw_hs, w_hs, w_cnt_last, w_end, w_beat_ok, aw_ill;
    logic [1:0]  w_beat_resp, w_proto_resp;
    logic        ar_hs, r_hs, r_cnt_last, ar_ill;
    logic [9:0]  ld_idx;
    logic        ld_ill;
    logic [31:0] ld_data;
    logic [1:0]  ld_resp;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_awaddr[31:12], i_awaddr[1:0], i_araddr[31:12], i_araddr[1:0]};

    assign aw_ill       = (i_awsize != 3'd2) || (i_awburst == 2'b10);
    assign aw_hs        = i_awvalid && o_awready;
    assign w_hs         = i_wvalid && o_wready;
    assign w_cnt_last   = (w_cnt == w_len);
    assign w_end        = w_hs && (w_cnt_last || i_wlast);
    assign w_beat_ok    = !w_ill && in_range(w_idx);
    assign w_beat_resp  = w_ill ? RESP_SLVERR : (in_range(w_idx) ? RESP_OKAY : RESP_DECERR);
    assign w_proto_resp = (i_wlast != w_cnt_last) ? RESP_SLVERR : RESP_OKAY;

    // Write FSM state register
    always_ff @(posedge i_clk0 or posedge i_rst) begin
        if (i_rst) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    // Write FSM next state and handshake outputs
    always_comb begin
        w_next   = w_state;
        w_idle   = 1'b0;
        o_wready = 1'b0;
        o_bvalid = 1'b0;
        case (w_state)
            W_IDLE: begin
                w_idle = 1'b1;
                if (aw_hs) w_next = W_DATA;
            end
            W_DATA: begin
                o_wready = 1'b1;
                if (w_end) w_next = W_RESP;
            end
            W_RESP: begin
                o_bvalid = 1'b1;
                if (i_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
        o_awready = w_idle && !i_rst;
    end

    // Write burst tracking and response accumulation
    always_ff @(posedge i_clk0 or posedge i_rst) begin
        if (i_rst) begin
            w_idx   <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_fixed <= 1'b0;
            w_ill   <= 1'b0;
            o_bid   <= '0;
            o_bresp <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                o_bid   <= i_awid;
                w_idx   <= i_awaddr[11:2];
                w_len   <= i_awlen;
                w_cnt   <= '0;
                w_fixed <= (i_awburst == 2'b00);
                w_ill   <= aw_ill;
                o_bresp <= aw_ill ? RESP_SLVERR : RESP_OKAY;
            end
            if (w_hs) begin
                w_cnt   <= w_cnt + 4'd1;
                if (!w_fixed) w_idx <= w_idx + 10'd1;
                o_bresp <= worst(worst(o_bresp, w_beat_resp), w_proto_resp);
            end
        end
    end

    // Register storage with byte enables
    always_ff @(posedge i_clk0 or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(N_REG); i++) regs[i] <= '0;
        end else if (w_hs && w_beat_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wstrb[b]) regs[w_idx[IDX_W-1:0]][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_led = regs[LED_REG][LED_W-1:0];

    assign ar_ill     = (i_arsize != 3'd2) || (i_arburst == 2'b10);
    assign ar_hs      = i_arvalid && o_arready;
    assign r_hs       = o_rvalid && i_rready;
    assign r_cnt_last = (r_cnt == r_len);

    // Decode of the beat to be loaded: first beat on AR, next beat on R handshake
    always_comb begin
        ld_idx  = r_fixed ? r_idx : r_idx + 10'd1;
        ld_ill  = r_ill;
        if (r_state == R_IDLE) begin
            ld_idx = i_araddr[11:2];
            ld_ill = ar_ill;
        end
        ld_data = '0;
        ld_resp = RESP_SLVERR;
        if (!ld_ill) begin
            if (in_range(ld_idx)) begin
                ld_data = regs[ld_idx[IDX_W-1:0]];
                ld_resp = RESP_OKAY;
            end else begin
                ld_resp = RESP_DECERR;
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge i_clk0 or posedge i_rst) begin
        if (i_rst) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    // Read FSM next state and handshake outputs
    always_comb begin
        r_next   = r_state;
        r_idle   = 1'b0;
        o_rvalid = 1'b0;
        case (r_state)
            R_IDLE: begin
                r_idle = 1'b1;
                if (ar_hs) r_next = R_DATA;
            end
            R_DATA: begin
                o_rvalid = 1'b1;
                if (r_hs && r_cnt_last) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
        o_arready = r_idle && !i_rst;
    end

    // Read beat pipeline; data/resp/last only change on AR or R handshakes
    always_ff @(posedge i_clk0 or posedge i_rst) begin
        if (i_rst) begin
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_fixed <= 1'b0;
            r_ill   <= 1'b0;
            o_rid   <= '0;
            o_rdata <= '0;
            o_rresp <= RESP_OKAY;
            o_rlast <= 1'b0;
        end else if (ar_hs) begin
            o_rid   <= i_arid;
            r_idx   <= ld_idx;
            r_len   <= i_arlen;
            r_cnt   <= '0;
            r_fixed <= (i_arburst == 2'b00);
            r_ill   <= ar_ill;
            o_rdata <= ld_data;
            o_rresp <= ld_resp;
            o_rlast <= (i_arlen == 4'd0);
        end else if (r_hs) begin
            if (r_cnt_last) begin
                o_rlast <= 1'b0;
            end else begin
                r_idx   <= ld_idx;
                r_cnt   <= r_cnt + 4'd1;
                o_rdata <= ld_data;
                o_rresp <= ld_resp;
                o_rlast <= ((r_cnt + 4'd1) == r_len);
            end
        end
    end

endmodule

// File: tb/tb_axi3_regfile_s.sv
// Directed self-checking bench for axi3_regfile_s (N_REG=8, LED from reg0).
module tb_axi3_regfile_s;

    logic        i_clk0 = 1'b0;
    logic        i_rst;
    logic [11:0] i_awid, o_bid, i_arid, o_rid;
    logic [31:0] i_awaddr, i_araddr, i_wdata, o_rdata;
    logic [3:0]  i_awlen, i_arlen, i_wstrb;
    logic [2:0]  i_awsize, i_arsize;
    logic [1:0]  i_awburst, i_arburst, o_bresp, o_rresp;
    logic        i_awvalid, o_awready, i_wlast, i_wvalid, o_wready, o_bvalid, i_bready;
    logic        i_arvalid, o_arready, o_rlast, o_rvalid, i_rready;
    logic [7:0]  o_led;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wd [16];
    logic [1:0]  wr_resp;
    logic [11:0] wr_id;
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [31:0] st_data [16];
    logic        st_seen [16];
    logic [11:0] rd_id;

    always #5 i_clk0 = ~i_clk0;

    axi3_regfile_s dut (
        .i_clk0(i_clk0), .i_rst(i_rst),
        .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
        .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid),
        .o_wready(o_wready), .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid),
        .i_bready(i_bready), .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen),
        .i_arsize(i_arsize), .i_arburst(i_arburst), .i_arvalid(i_arvalid),
        .o_arready(o_arready), .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp),
        .o_rlast(o_rlast), .o_rvalid(o_rvalid), .i_rready(i_rready), .o_led(o_led)
    );

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [11:0] id, input int nbeats,
                             input int wlast_beat, input logic [3:0] strb);
        int n;
        i_awaddr = addr; i_awlen = len; i_awsize = size; i_awburst = burst; i_awid = id;
        i_awvalid = 1'b1;
        n = 0;
        while (!o_awready && n < 50) begin @(posedge i_clk0); #1; n++; end
        if (n >= 50) begin n_checks++; n_fail++; $display("FAIL aw_timeout awready never seen"); end
        @(posedge i_clk0); #1;
        i_awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            i_wdata = wd[b]; i_wstrb = strb; i_wlast = (b == wlast_beat); i_wvalid = 1'b1;
            n = 0;
            while (!o_wready && n < 50) begin @(posedge i_clk0); #1; n++; end
            if (n >= 50) begin n_checks++; n_fail++; $display("FAIL w_timeout beat %0d", b); end
            @(posedge i_clk0); #1;
        end
        i_wvalid = 1'b0; i_wlast = 1'b0;
        i_bready = 1'b1;
        n = 0;
        while (!o_bvalid && n < 50) begin @(posedge i_clk0); #1; n++; end
        if (n >= 50) begin n_checks++; n_fail++; $display("FAIL b_timeout bvalid never seen"); end
        wr_resp = o_bresp; wr_id = o_bid;
        @(posedge i_clk0); #1;
        i_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [11:0] id, input logic toggle);
        int n, got, cyc;
        for (int k = 0; k < 16; k++) begin st_seen[k] = 1'b0; rd_data[k] = 'x; end
        i_araddr = addr; i_arlen = len; i_arsize = size; i_arburst = burst; i_arid = id;
        i_arvalid = 1'b1;
        n = 0;
        while (!o_arready && n < 50) begin @(posedge i_clk0); #1; n++; end
        if (n >= 50) begin n_checks++; n_fail++; $display("FAIL ar_timeout arready never seen"); end
        @(posedge i_clk0); #1;
        i_arvalid = 1'b0;
        got = 0; cyc = 0;
        while (got < int'(len) + 1 && cyc < 200) begin
            i_rready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (o_rvalid && i_rready) begin
                rd_data[got] = o_rdata; rd_resp[got] = o_rresp; rd_last[got] = o_rlast; rd_id = o_rid;
                got++;
            end else if (o_rvalid) begin
                st_data[got] = o_rdata; st_seen[got] = 1'b1;
            end
            @(posedge i_clk0); #1;
            cyc++;
        end
        i_rready = 1'b0;
        if (cyc >= 200) begin n_checks++; n_fail++; $display("FAIL r_timeout got %0d beats", got); end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_awid = '0; i_awaddr = '0; i_awlen = '0; i_awsize = 3'd2; i_awburst = 2'b01; i_awvalid = 1'b0;
        i_wdata = '0; i_wstrb = '0; i_wlast = 1'b0; i_wvalid = 1'b0; i_bready = 1'b0;
        i_arid = '0; i_araddr = '0; i_arlen = '0; i_arsize = 3'd2; i_arburst = 2'b01; i_arvalid = 1'b0;
        i_rready = 1'b0;
        #1;
        n_checks++; if (o_awready !== 1'b0) begin n_fail++; $display("FAIL rst_awready got %b exp 0", o_awready); end
        n_checks++; if (o_arready !== 1'b0) begin n_fail++; $display("FAIL rst_arready got %b exp 0", o_arready); end
        repeat (2) @(posedge i_clk0);
        @(negedge i_clk0); i_rst = 1'b0;
        @(posedge i_clk0); #1;
        n_checks++; if (o_awready !== 1'b1) begin n_fail++; $display("FAIL post_rst_awready got %b exp 1", o_awready); end
        n_checks++; if (o_arready !== 1'b1) begin n_fail++; $display("FAIL post_rst_arready got %b exp 1", o_arready); end
        n_checks++; if ({o_bvalid, o_rvalid, o_wready, o_rlast} !== 4'b0) begin n_fail++; $display("FAIL rst_valids got %b exp 0000", {o_bvalid, o_rvalid, o_wready, o_rlast}); end
        n_checks++; if (o_led !== 8'h00) begin n_fail++; $display("FAIL rst_led got %h exp 00", o_led); end
        n_checks++; if ({o_bid, o_rid, o_rdata, o_bresp, o_rresp} !== '0) begin n_fail++; $display("FAIL rst_outs got %h exp 0", {o_bid, o_rid, o_rdata, o_bresp, o_rresp}); end
    endtask

    task automatic test_single();
        wd[0] = 32'hA5A5_1234;
        axi_write(32'h004, 4'd0, 3'd2, 2'b01, 12'h03A, 1, 0, 4'hF);
        n_checks++; if (wr_resp !== 2'b00) begin n_fail++; $display("FAIL single_bresp got %h exp 0", wr_resp); end
        n_checks++; if (wr_id !== 12'h03A) begin n_fail++; $display("FAIL single_bid got %h exp 03a", wr_id); end
        axi_read(32'h004, 4'd0, 3'd2, 2'b01, 12'h015, 1'b0);
        n_checks++; if (rd_data[0] !== 32'hA5A5_1234) begin n_fail++; $display("FAIL single_rdata got %h exp a5a51234", rd_data[0]); end
        n_checks++; if (rd_last[0] !== 1'b1) begin n_fail++; $display("FAIL single_rlast got %b exp 1", rd_last[0]); end
        n_checks++; if (rd_resp[0] !== 2'b00) begin n_fail++; $display("FAIL single_rresp got %h exp 0", rd_resp[0]); end
        n_checks++; if (rd_id !== 12'h015) begin n_fail++; $display("FAIL single_rid got %h exp 015", rd_id); end
    endtask

    task automatic test_strobes();
        wd[0] = 32'h1122_3344;
        axi_write(32'h000, 4'd0, 3'd2, 2'b01, 12'h001, 1, 0, 4'hF);
        wd[0] = 32'hFFFF_FFFF;
        axi_write(32'h000, 4'd0, 3'd2, 2'b01, 12'h002, 1, 0, 4'h5);
        axi_read(32'h000, 4'd0, 3'd2, 2'b01, 12'h003, 1'b0);
        n_checks++; if (rd_data[0] !== 32'h11FF_33FF) begin n_fail++; $display("FAIL strobe_rdata got %h exp 11ff33ff", rd_data[0]); end
        n_checks++; if (o_led !== 8'hFF) begin n_fail++; $display("FAIL strobe_led got %h exp ff", o_led); end
    endtask

    task automatic test_incr_burst();
        logic [31:0] exp_d [4];
        exp_d = '{32'd1, 32'd2, 32'd3, 32'd4};
        for (int k = 0; k < 4; k++) wd[k] = exp_d[k];
        axi_write(32'h000, 4'd3, 3'd2, 2'b01, 12'h0AB, 4, 3, 4'hF);
        n_checks++; if (wr_resp !== 2'b00) begin n_fail++; $display("FAIL incr_bresp got %h exp 0", wr_resp); end
        n_checks++; if (o_led !== 8'h01) begin n_fail++; $display("FAIL incr_led got %h exp 01", o_led); end
        axi_read(32'h000, 4'd3, 3'd2, 2'b01, 12'h0CD, 1'b1);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (rd_data[k] !== exp_d[k]) begin n_fail++; $display("FAIL incr_rdata%0d got %h exp %h", k, rd_data[k], exp_d[k]); end
            n_checks++; if (rd_last[k] !== (k == 3)) begin n_fail++; $display("FAIL incr_rlast%0d got %b exp %b", k, rd_last[k], k == 3); end
        end
        for (int k = 1; k < 4; k++) begin
            n_checks++; if (st_seen[k] !== 1'b1 || st_data[k] !== exp_d[k]) begin n_fail++; $display("FAIL incr_stall%0d got %h seen %b exp %h", k, st_data[k], st_seen[k], exp_d[k]); end
        end
    endtask

    task automatic test_range();
        logic [31:0] exp_d [4];
        logic [1:0]  exp_r [4];
        exp_d = '{32'h61, 32'h71, 32'h0, 32'h0};
        exp_r = '{2'b00, 2'b00, 2'b11, 2'b11};
        wd[0] = 32'h61; wd[1] = 32'h71; wd[2] = 32'h81; wd[3] = 32'h91;
        axi_write(32'h018, 4'd3, 3'd2, 2'b01, 12'h010, 4, 3, 4'hF);
        n_checks++; if (wr_resp !== 2'b11) begin n_fail++; $display("FAIL range_bresp got %h exp 3", wr_resp); end
        axi_read(32'h018, 4'd3, 3'd2, 2'b01, 12'h011, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (rd_data[k] !== exp_d[k] || rd_resp[k] !== exp_r[k]) begin n_fail++; $display("FAIL range_beat%0d got %h/%h exp %h/%h", k, rd_data[k], rd_resp[k], exp_d[k], exp_r[k]); end
        end
        axi_read(32'h000, 4'd1, 3'd2, 2'b01, 12'h012, 1'b0);
        n_checks++; if (rd_data[0] !== 32'd1 || rd_data[1] !== 32'd2) begin n_fail++; $display("FAIL range_alias got %h %h exp 1 2", rd_data[0], rd_data[1]); end
    endtask

    task automatic test_illegal();
        axi_read(32'h000, 4'd1, 3'd1, 2'b01, 12'h020, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (rd_data[k] !== 32'h0 || rd_resp[k] !== 2'b10) begin n_fail++; $display("FAIL illsize_beat%0d got %h/%h exp 0/2", k, rd_data[k], rd_resp[k]); end
        end
        wd[0] = 32'hDEAD;
        axi_write(32'h00C, 4'd0, 3'd2, 2'b10, 12'h021, 1, 0, 4'hF);
        n_checks++; if (wr_resp !== 2'b10) begin n_fail++; $display("FAIL wrap_bresp got %h exp 2", wr_resp); end
        axi_read(32'h00C, 4'd0, 3'd2, 2'b01, 12'h022, 1'b0);
        n_checks++; if (rd_data[0] !== 32'd4) begin n_fail++; $display("FAIL wrap_nostore got %h exp 4", rd_data[0]); end
    endtask

    task automatic test_fixed();
        wd[0] = 32'd7; wd[1] = 32'd8; wd[2] = 32'd9;
        axi_write(32'h008, 4'd2, 3'd2, 2'b00, 12'h030, 3, 2, 4'hF);
        n_checks++; if (wr_resp !== 2'b00) begin n_fail++; $display("FAIL fixed_bresp got %h exp 0", wr_resp); end
        axi_read(32'h008, 4'd1, 3'd2, 2'b01, 12'h031, 1'b0);
        n_checks++; if (rd_data[0] !== 32'd9) begin n_fail++; $display("FAIL fixed_reg2 got %h exp 9", rd_data[0]); end
        n_checks++; if (rd_data[1] !== 32'd4) begin n_fail++; $display("FAIL fixed_reg3 got %h exp 4", rd_data[1]); end
        axi_read(32'h008, 4'd1, 3'd2, 2'b00, 12'h032, 1'b0);
        n_checks++; if (rd_data[0] !== 32'd9 || rd_data[1] !== 32'd9 || rd_last[1] !== 1'b1) begin n_fail++; $display("FAIL fixed_read got %h %h last %b exp 9 9 1", rd_data[0], rd_data[1], rd_last[1]); end
    endtask

    task automatic test_wlast();
        wd[0] = 32'h55;
        axi_write(32'h014, 4'd1, 3'd2, 2'b01, 12'h040, 1, 0, 4'hF);
        n_checks++; if (wr_resp !== 2'b10) begin n_fail++; $display("FAIL early_wlast_bresp got %h exp 2", wr_resp); end
        axi_read(32'h014, 4'd1, 3'd2, 2'b01, 12'h041, 1'b0);
        n_checks++; if (rd_data[0] !== 32'h55 || rd_data[1] !== 32'h61) begin n_fail++; $display("FAIL early_wlast_regs got %h %h exp 55 61", rd_data[0], rd_data[1]); end
        wd[0] = 32'h44;
        axi_write(32'h010, 4'd0, 3'd2, 2'b01, 12'h042, 1, -1, 4'hF);
        n_checks++; if (wr_resp !== 2'b10) begin n_fail++; $display("FAIL missing_wlast_bresp got %h exp 2", wr_resp); end
        axi_read(32'h010, 4'd0, 3'd2, 2'b01, 12'h043, 1'b0);
        n_checks++; if (rd_data[0] !== 32'h44) begin n_fail++; $display("FAIL missing_wlast_reg got %h exp 44", rd_data[0]); end
    endtask

    task automatic test_latency();
        i_awaddr = 32'h01C; i_awlen = 4'd0; i_awsize = 3'd2; i_awburst = 2'b01; i_awid = 12'h005;
        i_awvalid = 1'b1;
        n_checks++; if (o_awready !== 1'b1) begin n_fail++; $display("FAIL lat_awready got %b exp 1", o_awready); end
        n_checks++; if (o_wready !== 1'b0) begin n_fail++; $display("FAIL lat_wready_idle got %b exp 0", o_wready); end
        @(posedge i_clk0); #1;
        i_awvalid = 1'b0;
        i_wdata = 32'h77; i_wstrb = 4'hF; i_wlast = 1'b1; i_wvalid = 1'b1;
        n_checks++; if (o_wready !== 1'b1 || o_bvalid !== 1'b0) begin n_fail++; $display("FAIL lat_t1 got wready %b bvalid %b exp 1 0", o_wready, o_bvalid); end
        @(posedge i_clk0); #1;
        i_wvalid = 1'b0; i_wlast = 1'b0;
        n_checks++; if (o_bvalid !== 1'b1 || o_bid !== 12'h005 || o_bresp !== 2'b00) begin n_fail++; $display("FAIL lat_t2 got bvalid %b bid %h bresp %h exp 1 005 0", o_bvalid, o_bid, o_bresp); end
        i_bready = 1'b1;
        @(posedge i_clk0); #1;
        i_bready = 1'b0;
        n_checks++; if (o_bvalid !== 1'b0 || o_awready !== 1'b1) begin n_fail++; $display("FAIL lat_done got bvalid %b awready %b exp 0 1", o_bvalid, o_awready); end
    endtask

    task automatic test_reset_mid();
        i_awaddr = 32'h000; i_awlen = 4'd3; i_awsize = 3'd2; i_awburst = 2'b01; i_awid = 12'h050;
        i_awvalid = 1'b1;
        @(posedge i_clk0); #1;
        i_awvalid = 1'b0;
        i_araddr = 32'h000; i_arlen = 4'd3; i_arsize = 3'd2; i_arburst = 2'b01; i_arid = 12'h051;
        i_arvalid = 1'b1;
        @(posedge i_clk0); #1;
        i_arvalid = 1'b0;
        i_rready = 1'b1;
        repeat (2) begin @(posedge i_clk0); #1; end
        i_rready = 1'b0;
        n_checks++; if (o_rvalid !== 1'b1 || o_rdata !== 32'd9 || o_wready !== 1'b1) begin n_fail++; $display("FAIL mid_pre got rvalid %b rdata %h wready %b exp 1 9 1", o_rvalid, o_rdata, o_wready); end
        #2 i_rst = 1'b1;
        #1;
        n_checks++; if ({o_rvalid, o_bvalid, o_wready, o_rlast} !== 4'b0) begin n_fail++; $display("FAIL mid_valids got %b exp 0000", {o_rvalid, o_bvalid, o_wready, o_rlast}); end
        n_checks++; if (o_awready !== 1'b0 || o_arready !== 1'b0) begin n_fail++; $display("FAIL mid_ready got %b %b exp 0 0", o_awready, o_arready); end
        n_checks++; if (o_led !== 8'h00 || o_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_clear got led %h rdata %h exp 00 0", o_led, o_rdata); end
        @(posedge i_clk0);
        @(negedge i_clk0); i_rst = 1'b0;
        @(posedge i_clk0); #1;
        n_checks++; if (o_awready !== 1'b1 || o_arready !== 1'b1) begin n_fail++; $display("FAIL mid_release got %b %b exp 1 1", o_awready, o_arready); end
        axi_read(32'h000, 4'd7, 3'd2, 2'b01, 12'h052, 1'b0);
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (rd_data[k] !== 32'h0 || rd_resp[k] !== 2'b00) begin n_fail++; $display("FAIL mid_reg%0d got %h/%h exp 0/0", k, rd_data[k], rd_resp[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_strobes();
        test_incr_burst();
        test_range();
        test_illegal();
        test_fixed();
        test_wlast();
        test_latency();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
